data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width.
REQ-002 SHALL have parameter DEPTH_LOG2, default 8, log2 of words stored (256 words).
REQ-003 SHALL have parameter LAT, default 2, request-to-acknowledge latency in cycles; legal range 1..15.
REQ-004 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port data_read  input  1  load request from vector processor.
REQ-007 SHALL have port data_write  input  1  store request from vector processor.
REQ-008 SHALL have port data_memory_direction  input  32  byte address of the request.
REQ-009 SHALL have port data_store_mem  input  DATA_W  store data.
REQ-010 SHALL have port data_load_mem  output  DATA_W  load data, registered.
REQ-011 SHALL have port data_ack  output  1  one-cycle completion pulse.
REQ-012 SHALL have port data_busy  output  1  high while a request is in flight.
REQ-013 SHALL have port data_err  output  1  one-cycle error pulse, coincident with data_ack.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 SHALL sample data_read, data_write, address and store data only in IDLE; inputs in WAIT or RESP are ignored.
REQ-016 IDLE: on data_read or data_write, SHALL latch the request and go to WAIT when LAT>1, or to RESP when LAT==1.
REQ-017 WAIT: SHALL count down LAT-1 cycles, then go to RESP.
REQ-018 RESP: SHALL assert data_ack for exactly one cycle, then return to IDLE.
REQ-019 A request sampled at edge N SHALL have data_ack high in the cycle after edge N+LAT-1; back-to-back requests SHALL be spaced at least LAT+1 cycles apart.
REQ-020 data_busy SHALL be high in WAIT and RESP, and low in IDLE.
REQ-021 Word index SHALL be address bits [DEPTH_LOG2+1:2]; address bits [1:0] SHALL be ignored.
REQ-022 Store SHALL write the latched data to the latched index on the edge ending RESP.
REQ-023 Load SHALL present the stored word on data_load_mem in the RESP cycle, held until the next load's RESP.
REQ-024 data_read and data_write both high in IDLE SHALL be an error: no memory access, data_err with data_ack, data_load_mem unchanged.

Reset
REQ-025 Reset low SHALL immediately force IDLE, set data_load_mem to 0, set data_ack, data_busy and data_err to 0, and clear the latency counter.
REQ-026 Reset asserted mid-operation SHALL abort the request without a write or an ack; memory contents SHALL NOT be cleared by reset.
REQ-027 After reset deasserts, the first request SHALL be sampled no earlier than the first rising edge with reset high.

Configuration
REQ-028 Macro DMEM_RANGE_CHECK_EN defined: an address with any bit above DEPTH_LOG2+1 set SHALL complete with data_ack and data_err, perform no write, and leave data_load_mem unchanged.
REQ-029 Macro DMEM_RANGE_CHECK_EN undefined: upper address bits SHALL be ignored (wrap modulo depth); data_err SHALL assert only for REQ-024.

Verification
REQ-030 Store 0xDEADBEEF at address 0x10 with LAT=2 -> busy high 2 cycles; ack in the 2nd cycle after the sampling edge; a later load from 0x10 returns 0xDEADBEEF on the ack cycle.
REQ-031 LAT=1: load from address 0x13 after a store of 0x12345678 to 0x10 -> ack on the first cycle after sampling; data 0x12345678 (byte bits ignored).
REQ-032 data_read and data_write both high at address 0x20 -> ack and err high in the same cycle; a subsequent load from 0x20 returns the prior contents.
REQ-033 Store to address 0x400 (DEPTH_LOG2=8): with DMEM_RANGE_CHECK_EN -> ack and err high, word 0 unchanged; without it -> word 0 is overwritten and err stays low.
REQ-034 Reset low during WAIT of a store 0xCAFEF00D to 0x04 -> no ack; busy drops immediately; after release, a load from 0x04 returns the old value.
REQ-035 A new request held high during WAIT or RESP -> ignored; only one ack is produced and the next request is accepted only once back in IDLE.

Source files
------------

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Word-addressed data memory that answers load/store requests from a vector
// processor after a fixed, parameterised latency. A request is captured only
// while the responder is idle. It then waits LAT-1 cycles and answers with a
// one-cycle acknowledge. A store is committed on the clock edge that ends the
// acknowledge cycle. Memory contents survive reset.
//
// Optional feature (compile-time macro):
//   DMEM_RANGE_CHECK_EN - when defined, an address with any bit above the word
//                         index set is rejected with data_err. When undefined,
//                         upper address bits are ignored and addresses wrap
//                         modulo the depth.
//
// Parameters:
//   DATA_W     - data word width
//   DEPTH_LOG2 - log2 of the number of stored words
//   LAT        - request-to-acknowledge latency in cycles (1..15)
//
// Ports:
//   clock                 - single clock, rising edge
//   reset                 - asynchronous, active-low reset
//   data_read             - load request
//   data_write            - store request
//   data_memory_direction - byte address of the request
//   data_store_mem        - store data
//   data_load_mem         - registered load data, held until the next load
//   data_ack              - one-cycle completion pulse
//   data_busy             - high while a request is in flight
//   data_err              - one-cycle error pulse, coincident with data_ack
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 8,
  parameter int LAT        = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              data_read,
  input  logic              data_write,
  input  logic [31:0]       data_memory_direction,
  input  logic [DATA_W-1:0] data_store_mem,
  output logic [DATA_W-1:0] data_load_mem,
  output logic              data_ack,
  output logic              data_busy,
  output logic              data_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  // WAIT lasts LAT-1 cycles: the counter is loaded with LAT-2 and leaves at 0.
  localparam logic [3:0] WAIT_INIT = 4'((LAT > 1) ? (LAT - 2) : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W-1:0]     r_load;
  logic                  r_is_read;
  logic                  r_is_write;
  logic                  r_req_err;
  logic                  r_ack;
  logic                  r_busy;
  logic                  r_err;
  logic [DATA_W-1:0]     r_mem [DEPTH];

  logic                  w_req;
  logic                  w_conflict;
  logic                  w_range_err;
  logic                  w_req_err;
  logic                  w_mem_we;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_unused_addr;

`ifdef DMEM_RANGE_CHECK_EN
  // True when any address bit above the word index is set.
  function automatic logic f_out_of_range(input logic [31:0] addr);
    logic [31:0] upper;
    upper = addr >> (DEPTH_LOG2 + 2);
    return (upper != 32'd0);
  endfunction
`endif

  assign w_req      = data_read | data_write;
  assign w_conflict = data_read & data_write;
  assign w_idx      = data_memory_direction[DEPTH_LOG2+1:2];

  // Byte-lane bits never select anything; upper bits matter only with range checking.
  assign w_unused_addr = ^{data_memory_direction[1:0],
                           data_memory_direction[31:DEPTH_LOG2+2]};

  // Classify the incoming request as erroneous (conflict or out of range).
  always_comb begin
    w_range_err = 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
    if (f_out_of_range(data_memory_direction)) begin
      w_range_err = 1'b1;
    end else begin
      w_range_err = 1'b0;
    end
`endif
    w_req_err = w_conflict | w_range_err;
  end

  // A store commits on the edge that ends the acknowledge cycle; errors never write.
  assign w_mem_we = (r_state == S_RESP) & r_is_write & ~r_req_err;

  // Request FSM with registered acknowledge, busy, error and load data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_load     <= '0;
      r_is_read  <= 1'b0;
      r_is_write <= 1'b0;
      r_req_err  <= 1'b0;
      r_ack      <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ack <= 1'b0;
          r_err <= 1'b0;
          if (w_req) begin
            r_idx      <= w_idx;
            r_wdata    <= data_store_mem;
            r_is_read  <= data_read;
            r_is_write <= data_write;
            r_req_err  <= w_req_err;
            r_busy     <= 1'b1;
            if (LAT == 1) begin
              // Single-cycle latency: respond straight away, reading the live index.
              r_state <= S_RESP;
              r_ack   <= 1'b1;
              r_err   <= w_req_err;
              if (data_read && !w_req_err) begin
                r_load <= r_mem[w_idx];
              end
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= WAIT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_RESP;
            r_ack   <= 1'b1;
            r_err   <= r_req_err;
            if (r_is_read && !r_req_err) begin
              r_load <= r_mem[r_idx];
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Storage array; deliberately outside the reset domain so contents persist.
  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign data_load_mem = r_load;
  assign data_ack      = r_ack;
  assign data_busy     = r_busy;
  assign data_err      = r_err;

endmodule
